// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 4-bit nibble bus receiver: receive FSM state
// encoding, nibble/byte widths, default FIFO depth and timeout, and the
// odd-parity helper used when BUS_RX_PARITY_EN is defined.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOW_HELD = 2'd1,
    PUSH     = 2'd2
  } rx_state_e;

  // Returns 1 when {par, data} carries an odd number of ones.
  function automatic logic odd_par_ok(input logic par, input logic [NIBBLE_W-1:0] data);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/bus_rx_4bit_if.sv
// ---------------------------------------------------------------------------
// bus_rx_4bit_if
// Groups the nibble bus (remote tri-state driver side) and the byte read
// handshake of bus_rx_4bit.
//   bus_data[3:0]  nibble bus, meaningful only while bus_en=1
//   bus_en         remote driver enable, 1 = bus driven this cycle
//   bus_par        odd-parity bit for bus_data (only with BUS_RX_PARITY_EN)
//   rd_data[7:0]   FIFO head byte {high nibble, low nibble}
//   rd_valid       FIFO non-empty
//   rd_ready       consumer accepts rd_data
// Modports: master = remote driver + consumer, slave = receiver.
// Optional macro: BUS_RX_PARITY_EN adds bus_par.
// ---------------------------------------------------------------------------
interface bus_rx_4bit_if;
  import bus_pkg::*;

  logic [NIBBLE_W-1:0] bus_data;
  logic                bus_en;
`ifdef BUS_RX_PARITY_EN
  logic                bus_par;
`endif
  logic [BYTE_W-1:0]   rd_data;
  logic                rd_valid;
  logic                rd_ready;

`ifdef BUS_RX_PARITY_EN
  modport master (output bus_data, bus_en, bus_par, rd_ready,
                  input  rd_data, rd_valid);
  modport slave  (input  bus_data, bus_en, bus_par, rd_ready,
                  output rd_data, rd_valid);
`else
  modport master (output bus_data, bus_en, rd_ready,
                  input  rd_data, rd_valid);
  modport slave  (input  bus_data, bus_en, rd_ready,
                  output rd_data, rd_valid);
`endif

endinterface

// File: rtl/bus_rx_fifo.sv
// ---------------------------------------------------------------------------
// bus_rx_fifo
// Synchronous FIFO with power-of-two depth. A pop is applied before a push
// on the same edge, so a write into a full FIFO succeeds when a read is
// accepted simultaneously. rd_data is the head entry straight from storage.
//   clk, rst_n     clock, synchronous active-low reset
//   wr_en, wr_data push request and data
//   rd_en          pop request (ignored when empty)
//   rd_data        head entry
//   full, empty    occupancy status
// ---------------------------------------------------------------------------
module bus_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_rd_s;
  logic             do_wr_s;

  assign empty   = (count_r == {CW{1'b0}});
  assign full    = (count_r == CW'(DEPTH));
  assign rd_data = mem_r[rd_ptr_r];

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);

  // Storage, pointers (wrap naturally at DEPTH) and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bus_rx_4bit.sv
// ---------------------------------------------------------------------------
// bus_rx_4bit
// Receives bytes as two nibbles (low first) from a shared tri-state nibble
// bus and queues them in a byte FIFO. A partial byte is discarded if the
// high nibble does not arrive within TIMEOUT idle cycles.
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   bus            bus_rx_4bit_if.slave (nibble bus + read handshake)
//   err_clr        clears sticky flags on the next edge (a new event wins)
//   overflow       sticky: byte dropped because the FIFO was full
//   timeout_err    sticky: partial byte discarded by timeout
//   par_err        sticky: nibble with bad odd parity (0 without the macro)
// Optional macro: BUS_RX_PARITY_EN enables bus_par checking; a byte with a
// bad nibble is dropped.
// Byte path: high nibble captured on edge N -> PUSH; edge N+1 registers the
// push strobe; edge N+2 writes the FIFO, so rd_valid rises after edge N+2.
// ---------------------------------------------------------------------------
module bus_rx_4bit
  import bus_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_rx_4bit_if.slave bus,
  input  logic         err_clr,
  output logic         overflow,
  output logic         timeout_err,
  output logic         par_err
);

  // Last counter value before the timeout fires.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  rx_state_e           state_r;
  logic [NIBBLE_W-1:0] lo_r;
  logic [BYTE_W-1:0]   push_byte_r;
  logic                push_r;
  logic [7:0]          cnt_r;
  logic                overflow_r;
  logic                timeout_err_r;
  logic                keep_s;

  logic [BYTE_W-1:0]   rd_data_s;
  logic                full_s;
  logic                empty_s;
  logic                rd_valid_s;
  logic                pop_s;
  logic                ovf_evt_s;

  assign rd_valid_s   = ~empty_s;
  assign pop_s        = rd_valid_s & bus.rd_ready;
  assign ovf_evt_s    = push_r & full_s & ~pop_s;
  assign bus.rd_valid = rd_valid_s;
  assign bus.rd_data  = rd_data_s;
  assign overflow     = overflow_r;
  assign timeout_err  = timeout_err_r;

`ifdef BUS_RX_PARITY_EN
  logic bad_r;
  logic par_err_r;
  logic nib_bad_s;

  // Only a driven bus can report a parity fault.
  assign nib_bad_s = bus.bus_en & ~odd_par_ok(bus.bus_par, bus.bus_data);
  assign keep_s    = ~bad_r;
  assign par_err   = par_err_r;

  // Tracks whether the byte being assembled has a bad nibble, plus the sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bad_r     <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= (par_err_r & ~err_clr) | nib_bad_s;
      case (state_r)
        IDLE:     bad_r <= bus.bus_en ? nib_bad_s : bad_r;
        LOW_HELD: bad_r <= bus.bus_en ? (bad_r | nib_bad_s) : bad_r;
        PUSH:     bad_r <= nib_bad_s;
        default:  bad_r <= 1'b0;
      endcase
    end
  end
`else
  assign keep_s  = 1'b1;
  assign par_err = 1'b0;
`endif

  // Receive FSM: nibble capture, timeout, push strobe and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      lo_r          <= {NIBBLE_W{1'b0}};
      push_byte_r   <= {BYTE_W{1'b0}};
      push_r        <= 1'b0;
      cnt_r         <= 8'd0;
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      push_r        <= 1'b0;
      overflow_r    <= (overflow_r & ~err_clr) | ovf_evt_s;
      timeout_err_r <= timeout_err_r & ~err_clr;
      case (state_r)
        IDLE: begin
          if (bus.bus_en) begin
            lo_r    <= bus.bus_data;
            cnt_r   <= 8'd0;
            state_r <= LOW_HELD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOW_HELD: begin
          if (bus.bus_en) begin
            push_byte_r <= {bus.bus_data, lo_r};
            state_r     <= PUSH;
          end else if (cnt_r == TO_LAST) begin
            timeout_err_r <= 1'b1;
            cnt_r         <= 8'd0;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        PUSH: begin
          push_r <= keep_s;
          // A nibble arriving right behind the high nibble starts the next byte.
          if (bus.bus_en) begin
            lo_r    <= bus.bus_data;
            cnt_r   <= 8'd0;
            state_r <= LOW_HELD;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  bus_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_r),
    .wr_data (push_byte_r),
    .rd_en   (pop_s),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s)
  );

endmodule

// File: tb/tb_bus_rx_4bit.sv
// ---------------------------------------------------------------------------
// tb_bus_rx_4bit
// Directed self-checking bench for bus_rx_4bit (FIFO_DEPTH=4, TIMEOUT=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_bus_rx_4bit;

  logic clk;
  logic rst_n;
  logic err_clr;
  logic overflow;
  logic timeout_err;
  logic par_err;

  int checks = 0;
  int errors = 0;

  bus_rx_4bit_if bif ();

  bus_rx_4bit #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif.slave),
    .err_clr     (err_clr),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .par_err     (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle; an idle bus floats to X.
  task automatic drive(input logic en, input logic [3:0] d);
    bif.bus_en   = en;
    bif.bus_data = en ? d : 4'bxxxx;
`ifdef BUS_RX_PARITY_EN
    bif.bus_par  = ~(^d);
`endif
  endtask

  // Low nibble then high nibble on consecutive edges.
  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, b[3:0]);
    tick();
    drive(1'b1, b[7:4]);
    tick();
  endtask

  logic [7:0] t3 [5];
  logic [7:0] t4 [5];

  initial begin
    t3 = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98};
    t4 = '{8'h1F, 8'h2E, 8'h3D, 8'h4C, 8'h5B};

    // Reset state
    rst_n        = 1'b0;
    err_clr      = 1'b0;
    bif.rd_ready = 1'b0;
    drive(1'b0, 4'h0);
    tick();
    tick();
    check("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bif.rd_data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x5, 0xA -> 0xA5, valid two edges after the high nibble, one cycle only
    bif.rd_ready = 1'b1;
    send_byte(8'hA5);
    drive(1'b0, 4'h0);
    tick();
    check("lat_not_yet", 32'(bif.rd_valid), 32'd0);
    tick();
    check("lat_valid", 32'(bif.rd_valid), 32'd1);
    check("lat_data", 32'(bif.rd_data), 32'hA5);
    tick();
    check("lat_one_cycle", 32'(bif.rd_valid), 32'd0);

    // Timeout after 8 idle cycles, then a normal pair
    drive(1'b1, 4'h3);
    tick();
    drive(1'b0, 4'h0);
    for (int i = 0; i < 7; i++) tick();
    check("to_before", 32'(timeout_err), 32'd0);
    tick();
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_no_write", 32'(bif.rd_valid), 32'd0);
    send_byte(8'h21);
    drive(1'b0, 4'h0);
    tick();
    tick();
    check("to_next_valid", 32'(bif.rd_valid), 32'd1);
    check("to_next_data", 32'(bif.rd_data), 32'h21);
    tick();
    check("to_next_popped", 32'(bif.rd_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clear", 32'(timeout_err), 32'd0);

    // err_clr on the same edge as a timeout: the set wins
    drive(1'b1, 4'h8);
    tick();
    drive(1'b0, 4'h0);
    for (int i = 0; i < 7; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_vs_set", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_after", 32'(timeout_err), 32'd0);

    // Overflow: five back-to-back bytes into a depth-4 FIFO
    bif.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(t3[i]);
    drive(1'b0, 4'h0);
    tick();
    tick();
    tick();
    check("ovf_set", 32'(overflow), 32'd1);
    bif.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_valid", 32'(bif.rd_valid), 32'd1);
      check("ovf_drain_data", 32'(bif.rd_data), 32'(t3[i]));
      tick();
    end
    check("ovf_drain_empty", 32'(bif.rd_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full FIFO: push and pop on the same edge
    bif.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(t4[i]);
    drive(1'b0, 4'h0);
    tick();
    tick();
    tick();
    check("full_no_ovf", 32'(overflow), 32'd0);
    check("full_head", 32'(bif.rd_data), 32'(t4[0]));
    send_byte(t4[4]);
    drive(1'b0, 4'h0);
    tick();
    bif.rd_ready = 1'b1;
    tick();
    bif.rd_ready = 1'b0;
    check("pp_no_ovf", 32'(overflow), 32'd0);
    bif.rd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("pp_drain_valid", 32'(bif.rd_valid), 32'd1);
      check("pp_drain_data", 32'(bif.rd_data), 32'(t4[i]));
      tick();
    end
    check("pp_drain_empty", 32'(bif.rd_valid), 32'd0);

    // Reset while holding a low nibble
    drive(1'b1, 4'h9);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 4'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("mid_rst_no_timeout", 32'(timeout_err), 32'd0);
    check("mid_rst_no_data", 32'(bif.rd_valid), 32'd0);
    send_byte(8'h64);
    drive(1'b0, 4'h0);
    tick();
    tick();
    check("mid_rst_valid", 32'(bif.rd_valid), 32'd1);
    check("mid_rst_data", 32'(bif.rd_data), 32'h64);
    tick();
    check("mid_rst_single", 32'(bif.rd_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_par", 32'(par_err), 32'd0);

`ifdef BUS_RX_PARITY_EN
    // Nibble 0x7 with bus_par=1 has even parity: flag set, byte dropped
    bif.bus_en   = 1'b1;
    bif.bus_data = 4'h7;
    bif.bus_par  = 1'b1;
    tick();
    drive(1'b1, 4'h1);
    tick();
    drive(1'b0, 4'h0);
    tick();
    tick();
    check("par_set", 32'(par_err), 32'd1);
    check("par_dropped", 32'(bif.rd_valid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("par_clear", 32'(par_err), 32'd0);
    send_byte(8'h3C);
    drive(1'b0, 4'h0);
    tick();
    tick();
    check("par_good_data", 32'(bif.rd_data), 32'h3C);
    check("par_good_flag", 32'(par_err), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_rx_4bit.md
BUS_RX_4BIT -- requirements
Module: bus_rx_4bit

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of byte entries in the receive FIFO (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 8, idle cycles allowed between low and high nibble before the partial byte is discarded (1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 bus_data  input  4  shared tri-state nibble bus, valid only while bus_en=1.
REQ-006 bus_en  input  1  driver enable of the remote tri-state buffer; 1 = bus driven this cycle.
REQ-007 bus_par  input  1  odd-parity bit for bus_data; present only with BUS_RX_PARITY_EN.
REQ-008 rd_data  output  8  FIFO head byte, {high nibble, low nibble}.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 rd_ready  input  1  consumer accepts rd_data when rd_valid=1.
REQ-011 overflow  output  1  sticky: byte dropped because the FIFO was full.
REQ-012 timeout_err  output  1  sticky: partial byte discarded by timeout.
REQ-013 par_err  output  1  sticky parity error; tied 0 without BUS_RX_PARITY_EN.
REQ-014 err_clr  input  1  clears all sticky flags on the next edge.

Function
REQ-015 Bus values shall be sampled only on edges where bus_en=1; bus_data with bus_en=0 (high-Z/X) shall never affect state.
REQ-016 FSM states: IDLE, LOW_HELD, PUSH.
REQ-017 IDLE: on bus_en=1, capture bus_data as low nibble, clear the timeout counter, go to LOW_HELD.
REQ-018 LOW_HELD: on bus_en=1, capture the high nibble and go to PUSH; otherwise increment the counter; when the counter reaches TIMEOUT, set timeout_err, discard the low nibble, go to IDLE.
REQ-019 PUSH: write the byte to the FIFO if not full, else set overflow and drop it; always return to IDLE in one cycle; bus_en=1 in PUSH shall be captured as the next low nibble and go to LOW_HELD (no lost nibble).
REQ-020 Latency: high nibble sampled on edge N shall produce rd_valid=1 after edge N+2 when the FIFO was empty.
REQ-021 Pop when rd_valid && rd_ready; rd_data shall be the head entry, combinationally from FIFO storage.
REQ-022 A simultaneous push and pop when full shall succeed (pop first), with no overflow.
REQ-023 FIFO pointers shall wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-024 err_clr with a simultaneous error event: the set shall win.

Reset
REQ-025 rst_n=0 at an edge: FSM to IDLE, FIFO empty, rd_valid=0, rd_data=0, all sticky flags 0, counter 0.
REQ-026 Reset mid-byte (LOW_HELD or PUSH) shall discard the partial byte without setting any flag.

Configuration
REQ-027 Macro BUS_RX_PARITY_EN: when defined, bus_par exists; each sampled nibble is checked for odd parity over {bus_par, bus_data}; on failure par_err is set and the byte containing that nibble is dropped at PUSH.
REQ-028 Without BUS_RX_PARITY_EN: no bus_par port, no check logic, par_err constant 0.

Structure
REQ-029 Shared package bus_pkg: FSM state enum, NIBBLE_W=4, BYTE_W=8, default FIFO_DEPTH and TIMEOUT constants.
REQ-030 One sub-module, bus_rx_fifo (parameterised synchronous FIFO, push/pop/full/empty); the FSM stays in bus_rx_4bit.

Verification
REQ-031 Nibbles 0x5 then 0xA on consecutive bus_en cycles, rd_ready=1 -> rd_data=0xA5, rd_valid for one cycle, 2 cycles after the high nibble.
REQ-032 Low nibble 0x3, then bus_en=0 for TIMEOUT=8 cycles -> timeout_err=1, no FIFO write; next pair 0x1,0x2 -> 0x21.
REQ-033 rd_ready=0, send 5 bytes with FIFO_DEPTH=4 -> first 4 stored in order, overflow=1; drain -> exactly 4 bytes.
REQ-034 FIFO full, push and rd_ready=1 on the same edge -> no overflow, count stays 4, order preserved.
REQ-035 With BUS_RX_PARITY_EN: nibble 0x7 with bus_par=1 (even total) -> par_err=1, byte dropped; err_clr -> par_err=0.
REQ-036 rst_n=0 in LOW_HELD, then 0x4,0x6 -> single byte 0x64, all flags 0.
